// File: rtl/multdiv_iter.sv
// rtl/multdiv_iter.sv - iterative signed multiplier/divider, one step per cycle over WIDTH cycles
// Both ops work on operand magnitudes in a shared {hi, lo} register; the sign is applied at the last step.
module multdiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_next;

  logic [CW-1:0]      count;
  logic               is_div, neg;
  logic [WIDTH:0]     hi;
  logic [WIDTH-1:0]   lo, mag;
  logic               start, last, div_zero;

  logic [WIDTH:0]     add_sum, rem_sh, rem_sub, hi_next;
  logic               rem_ge;
  logic [WIDTH-1:0]   lo_next, quot;
  logic [2*WIDTH-1:0] prod_mag, prod;
  logic               mul_ovf, div_ovf;

  function automatic logic [WIDTH-1:0] mag_of(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  assign start    = ctrl_MULT | ctrl_DIV;
  assign div_zero = is_div && (mag == '0);
  assign last     = (count == CW'(WIDTH - 1)) || div_zero;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next     = state;
    data_resultRDY = 1'b0;
    case (state)
      IDLE: if (start) state_next = RUN;
      RUN:  if (last) state_next = DONE;
      DONE: begin
        data_resultRDY = 1'b1;
        state_next     = start ? RUN : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Multiply: shift-add with lo holding the multiplier. Divide: restoring, lo collects quotient bits.
  always_comb begin
    add_sum = hi + (lo[0] ? {1'b0, mag} : '0);
    rem_sh  = {hi[WIDTH-1:0], lo[WIDTH-1]};
    rem_sub = rem_sh - {1'b0, mag};
    rem_ge  = (rem_sh >= {1'b0, mag});
    hi_next = '0;
    lo_next = '0;
    if (is_div) begin
      hi_next = rem_ge ? rem_sub : rem_sh;
      lo_next = {lo[WIDTH-2:0], rem_ge};
    end else begin
      hi_next = {1'b0, add_sum[WIDTH:1]};
      lo_next = {add_sum[0], lo[WIDTH-1:1]};
    end
  end

  always_comb begin
    prod_mag = {hi_next[WIDTH-1:0], lo_next};
    prod     = neg ? -prod_mag : prod_mag;
    quot     = neg ? -lo_next : lo_next;
    mul_ovf  = !((&prod[2*WIDTH-1:WIDTH-1]) || !(|prod[2*WIDTH-1:WIDTH-1]));
    // Quotient magnitude tops out at 2^(WIDTH-1); only the positive case overflows.
    div_ovf  = !neg && lo_next[WIDTH-1];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count          <= '0;
      hi             <= '0;
      lo             <= '0;
      mag            <= '0;
      is_div         <= 1'b0;
      neg            <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
    end else if (start && state != RUN) begin
      count  <= '0;
      hi     <= '0;
      is_div <= !ctrl_MULT;
      neg    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      mag    <= ctrl_MULT ? mag_of(data_operandA) : mag_of(data_operandB);
      lo     <= ctrl_MULT ? mag_of(data_operandB) : mag_of(data_operandA);
    end else if (state == RUN) begin
      hi <= hi_next;
      lo <= lo_next;
      if (!last) count <= count + 1'b1;
      if (div_zero) begin
        data_result    <= '0;
        data_exception <= 1'b1;
      end else if (last) begin
        data_result    <= is_div ? quot : prod[WIDTH-1:0];
        data_exception <= is_div ? div_ovf : mul_ovf;
      end
    end
  end

endmodule

// File: tb/tb_multdiv_iter.sv
// tb/tb_multdiv_iter.sv - vector table, corner sequences and random ops against a scoreboard
module tb_multdiv_iter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] data_operandA = '0, data_operandB = '0;
  logic        ctrl_MULT = 1'b0, ctrl_DIV = 1'b0;
  logic [31:0] data_result;
  logic        data_exception, data_resultRDY;

  multdiv_iter #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .data_operandA(data_operandA), .data_operandB(data_operandB),
    .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .data_result(data_result), .data_exception(data_exception),
    .data_resultRDY(data_resultRDY)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          lat;
    int          start_cyc;
  } exp_t;

  typedef struct {
    logic        m;
    logic        d;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        exc;
    int          lat;
  } vec_t;

  exp_t sb[$];
  int   checks = 0, failures = 0;
  int   cyc = 0;
  logic chk_low = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (chk_low) begin
      checks++;
      chk_low = 1'b0;
      if (data_resultRDY) begin
        failures++;
        $display("FAIL rdy_width: rdy still 1 one cycle after strobe, required 0 (cyc %0d)", cyc);
      end
    end else if (data_resultRDY) begin
      chk_low = 1'b1;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_rdy: rdy=1 with no op outstanding (cyc %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checks += 3;
        if (data_result !== e.res) begin
          failures++;
          $display("FAIL result: got %h required %h", data_result, e.res);
        end
        if (data_exception !== e.exc) begin
          failures++;
          $display("FAIL exception: got %b required %b (result %h)", data_exception, e.exc, e.res);
        end
        if (cyc - e.start_cyc != e.lat) begin
          failures++;
          $display("FAIL latency: got %0d required %0d", cyc - e.start_cyc, e.lat);
        end
      end
    end
  end

  function automatic void model(input logic is_mul, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic e, output int lat);
    longint p, q;
    logic [32:0] top;
    lat = 32;
    if (is_mul) begin
      p   = longint'($signed(a)) * longint'($signed(b));
      r   = p[31:0];
      top = p[63:31];
      e   = !((&top) || !(|top));
    end else if (b == 32'h0) begin
      r   = 32'h0;
      e   = 1'b1;
      lat = 1;
    end else begin
      q = longint'($signed(a)) / longint'($signed(b));
      r = q[31:0];
      e = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    end
  endfunction

  // Called at a negedge; the start is sampled at the next rising edge.
  task automatic issue(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r, input logic e, input int lat);
    exp_t x;
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT = m;
    ctrl_DIV  = d;
    x.res = r; x.exc = e; x.lat = lat; x.start_cyc = cyc + 1;
    sb.push_back(x);
    @(negedge clk);
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL timeout: %0d ops outstanding after 60 cycles, required 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 32};
    vecs[1]  = '{1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1, 32};
    vecs[2]  = '{1'b0, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0, 32};
    vecs[3]  = '{1'b0, 1'b1, 32'h0000_0064, 32'h0000_0000, 32'h0000_0000, 1'b1, 1};
    vecs[4]  = '{1'b0, 1'b1, 32'h0000_0000, 32'h0000_0005, 32'h0000_0000, 1'b0, 32};
    vecs[5]  = '{1'b1, 1'b0, 32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 1'b0, 32};
    vecs[6]  = '{1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 32};
    vecs[7]  = '{1'b0, 1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 32};
    vecs[8]  = '{1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32};
    vecs[9]  = '{1'b1, 1'b0, 32'h7FFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, 1'b1, 32};
    vecs[10] = '{1'b0, 1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001, 1'b0, 32};
    vecs[11] = '{1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 32};

    repeat (2) @(negedge clk);
    checks += 3;
    if (data_result !== 32'h0) begin failures++; $display("FAIL reset_result: got %h required 0", data_result); end
    if (data_exception !== 1'b0) begin failures++; $display("FAIL reset_exc: got %b required 0", data_exception); end
    if (data_resultRDY !== 1'b0) begin failures++; $display("FAIL reset_rdy: got %b required 0", data_resultRDY); end
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      issue(vecs[i].m, vecs[i].d, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].exc, vecs[i].lat);
      wait_idle();
    end

    // Reset mid-run: the last vector left result=0x80000000, exception=1 behind.
    begin
      int rdy_seen;
      data_operandA = 32'h0000_0009; data_operandB = 32'h0000_0009; ctrl_MULT = 1'b1;
      @(negedge clk);
      ctrl_MULT = 1'b0;
      repeat (10) @(negedge clk);
      reset = 1'b0;
      #1;
      checks += 3;
      if (data_result !== 32'h0) begin failures++; $display("FAIL abort_result: got %h required 0", data_result); end
      if (data_exception !== 1'b0) begin failures++; $display("FAIL abort_exc: got %b required 0", data_exception); end
      if (data_resultRDY !== 1'b0) begin failures++; $display("FAIL abort_rdy: got %b required 0", data_resultRDY); end
      @(negedge clk);
      reset = 1'b1;
      rdy_seen = 0;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        if (data_resultRDY) rdy_seen++;
      end
      checks++;
      if (rdy_seen != 0) begin failures++; $display("FAIL abort_no_rdy: saw %0d strobes, required 0", rdy_seen); end
    end

    // DIV pulse during a MULT is ignored, as are operand changes after the start edge.
    issue(1'b1, 1'b0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 32);
    data_operandA = 32'h0000_0064; data_operandB = 32'h0000_0000;
    repeat (4) @(negedge clk);
    ctrl_DIV = 1'b1;
    @(negedge clk);
    ctrl_DIV = 1'b0;
    wait_idle();
    repeat (5) @(negedge clk);

    // Both starts together: multiply wins.
    issue(1'b1, 1'b1, 32'h0000_0006, 32'h0000_0003, 32'h0000_0012, 1'b0, 32);
    wait_idle();

    // Start in the DONE cycle.
    begin
      int n;
      issue(1'b1, 1'b0, 32'h0000_0005, 32'h0000_0005, 32'h0000_0019, 1'b0, 32);
      n = 0;
      while (!data_resultRDY && n < 40) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (!data_resultRDY) begin
        failures++;
        $display("FAIL b2b_first_rdy: rdy not seen in 40 cycles, required 1");
      end
      issue(1'b0, 1'b1, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 1'b0, 32);
      wait_idle();
    end

    for (int i = 0; i < 1000; i++) begin
      logic [31:0] a, b, r;
      logic        e, m;
      int          lat, sel;
      m   = $urandom_range(0, 1) == 1;
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 31);
      if (sel == 0) b = 32'h0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel < 6) b = {{16{b[31]}}, b[15:0]};
      else if (sel < 9) a = {{20{a[31]}}, a[11:0]};
      model(m, a, b, r, e, lat);
      issue(m, !m, a, b, r, e, lat);
      wait_idle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
